// File: rtl/ext_interrupt_ctrl.sv
// ext_interrupt_ctrl
//   Two-source external interrupt controller with a 4-word register window.
//   Each IRQ_In line is synchronised, rising edges latch a pending bit, and
//   masked-in pending sources are offered to the core one at a time through
//   a request/acknowledge pair. Source 0 has priority over source 1.
//
// Parameters
//   BASE_ADDR   word-address bits [29:2] of the register window
//   SYNC_STAGES input synchroniser depth (2..3)
//
// Optional feature
//   EIC_SWTRIG_EN  when defined, word 3 (SWSET) sets pending bits for each
//                  written 1 in [1:0]; when undefined, word 3 is inert.
//
// Ports
//   Sys_Clock   in   sole clock, rising edge
//   Sys_Reset   in   synchronous active-high reset
//   IRQ_In      in   [1:0] asynchronous interrupt lines, rising-edge triggered
//   EIC_IntReq  out  interrupt request to the core
//   EIC_IntId   out  ID of the requested source
//   EIC_IntAck  in   one-cycle acknowledge from the core
//   IO_EnR      in   read strobe
//   IO_EnW      in   write strobe
//   IO_Address  in   [29:0] word address
//   IO_DataW    in   [31:0] write data
//   IO_DataR    out  [31:0] read data, registered, 0 when no read last cycle
//
// Register map (word offset)
//   0 STATUS RO  [1:0] pending, [3:2] synchronised levels, [5:4] FSM state
//   1 MASK   RW  [1:0]
//   2 PCLR   W1C pending bits
//   3 SWSET  W1S pending bits (EIC_SWTRIG_EN only), reads 0
//
// Request/acknowledge handshake: EIC_IntReq acts as "valid" and EIC_IntAck as
// "ready". Once EIC_IntReq rises, it and EIC_IntId stay stable until the
// cycle in which EIC_IntAck is high; the transfer completes on that edge.
// EIC_IntAck outside an active request is ignored.

module ext_interrupt_ctrl #(
  parameter logic [27:0] BASE_ADDR   = 28'h000_0100,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        Sys_Clock,
  input  logic        Sys_Reset,
  input  logic [1:0]  IRQ_In,
  output logic        EIC_IntReq,
  output logic        EIC_IntId,
  input  logic        EIC_IntAck,
  input  logic        IO_EnR,
  input  logic        IO_EnW,
  input  logic [29:0] IO_Address,
  input  logic [31:0] IO_DataW,
  output logic [31:0] IO_DataR
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    GAP  = 2'b10
  } stateType;

  // The synchroniser and edge history both restart from 0 at reset, so edges
  // are only trusted once the chain and the history flop hold real samples.
  // That keeps a line that is already high at reset release from looking
  // like a fresh rising edge.
  localparam logic [2:0] FILL_DONE = 3'(SYNC_STAGES + 1);

  stateType    state;
  logic [1:0]  syncStage [SYNC_STAGES];
  logic [1:0]  syncLvl;
  logic [1:0]  irqPrev;
  logic [2:0]  fillCnt;
  logic        fillDone;
  logic [1:0]  irqEdge;
  logic [1:0]  pend;
  logic [1:0]  pendNext;
  logic [1:0]  mask;
  logic [1:0]  eligible;
  logic        inWindow;
  logic [1:0]  wordSel;
  logic        wrEn;
  logic        rdEn;
  logic [1:0]  pclrBits;
  logic [1:0]  swSetBits;
  logic [1:0]  ackClr;
  logic [31:0] readData;
  logic        unusedDataBits;

  assign syncLvl  = syncStage[SYNC_STAGES-1];
  assign fillDone = (fillCnt == FILL_DONE);
  assign irqEdge  = fillDone ? (syncLvl & ~irqPrev) : 2'b00;

  assign inWindow = (IO_Address[29:2] == BASE_ADDR);
  assign wordSel  = IO_Address[1:0];
  assign wrEn     = IO_EnW & inWindow;
  assign rdEn     = IO_EnR & inWindow;
  assign pclrBits = (wrEn && wordSel == 2'd2) ? IO_DataW[1:0] : 2'b00;

`ifdef EIC_SWTRIG_EN
  assign swSetBits = (wrEn && wordSel == 2'd3) ? IO_DataW[1:0] : 2'b00;
`else
  assign swSetBits = 2'b00;
`endif

  assign unusedDataBits = ^IO_DataW[31:2];

  // Acknowledge clears the source that was actually requested, which may no
  // longer be eligible by then.
  assign ackClr = (state == REQ && EIC_IntAck) ? (EIC_IntId ? 2'b10 : 2'b01) : 2'b00;

  // Set sources win over clear sources on the same bit; an edge on a source
  // that is already pending simply leaves it pending.
  assign pendNext = (pend & ~(pclrBits | ackClr)) | irqEdge | swSetBits;
  assign eligible = pend & mask;

  always_comb begin
    readData = 32'd0;
    case (wordSel)
      2'd0:    readData = {26'd0, state, syncLvl, pend};
      2'd1:    readData = {30'd0, mask};
      default: readData = 32'd0;
    endcase
  end

  // Input synchroniser, edge history and fill tracking.
  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) syncStage[k] <= 2'b00;
      irqPrev <= 2'b00;
      fillCnt <= 3'd0;
    end else begin
      syncStage[0] <= IRQ_In;
      for (int k = 1; k < SYNC_STAGES; k++) syncStage[k] <= syncStage[k-1];
      irqPrev <= syncLvl;
      if (!fillDone) fillCnt <= fillCnt + 3'd1;
    end
  end

  // Register file and read port.
  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      pend     <= 2'b00;
      mask     <= 2'b00;
      IO_DataR <= 32'd0;
    end else begin
      pend     <= pendNext;
      if (wrEn && wordSel == 2'd1) mask <= IO_DataW[1:0];
      IO_DataR <= rdEn ? readData : 32'd0;
    end
  end

  // Request FSM with registered request outputs.
  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      state      <= IDLE;
      EIC_IntReq <= 1'b0;
      EIC_IntId  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (eligible != 2'b00) begin
            state      <= REQ;
            EIC_IntReq <= 1'b1;
            EIC_IntId  <= ~eligible[0];
          end
        end
        REQ: begin
          if (EIC_IntAck) begin
            state      <= GAP;
            EIC_IntReq <= 1'b0;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          EIC_IntReq <= 1'b0;
        end
      endcase
    end
  end

endmodule
